apb2axi_txn_sched: RTL and testbench
====================================

Name: apb2axi_txn_sched

Overview:
- Issue scheduler between the tag directory and the AXI read/write request builders of the APB-to-AXI gateway.
- Every cycle it sees which directory tags are pending issue, and for writes whether the write data is fully buffered.
- It picks one read tag and one write tag per offer using independent round-robin arbiters, within per-direction outstanding limits.
- It tells the directory which tags were issued, and retires tags when the AXI side reports completion.

Parameters:
- TAG_NUM, 16, number of directory tags.
- TAG_W, 4, tag index width, equal to $clog2(TAG_NUM).
- MAX_RD_OUTST, 8, maximum read tags in flight (1..TAG_NUM).
- MAX_WR_OUTST, 8, maximum write tags in flight (1..TAG_NUM).
- CNT_W, 5, width of the outstanding counters; must hold TAG_NUM.

Ports:
- pclk  in  1  clock (single clock domain).
- presetn  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  when 0, no new offers are started.
- pend_vld  in  TAG_NUM  directory entry is pending issue.
- pend_is_write  in  TAG_NUM  direction of each entry (1 = write).
- wr_data_full  in  TAG_NUM  write data for the tag is fully buffered.
- rd_issue_vld  out  1  read issue offer.
- rd_issue_tag  out  TAG_W  tag being offered for read.
- rd_issue_rdy  in  1  read builder accepts the offer.
- wr_issue_vld  out  1  write issue offer.
- wr_issue_tag  out  TAG_W  tag being offered for write.
- wr_issue_rdy  in  1  write builder accepts the offer.
- issued_pulse  out  TAG_NUM  one-cycle flag per tag issued; marks the directory entry ISSUED.
- rd_done_vld  in  1  read completion, last beat seen.
- rd_done_tag  in  TAG_W  tag of the completed read.
- wr_done_vld  in  1  write completion, B response seen.
- wr_done_tag  in  TAG_W  tag of the completed write.
- rd_outst  out  CNT_W  read tags currently in flight.
- wr_outst  out  CNT_W  write tags currently in flight.
- sched_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync release):
  - all outputs are 0; in-flight bitmap is 0; both round-robin pointers are 0.
  - both channel FSMs are in IDLE.
- Eligibility, combinational:
  - read-eligible = pend_vld & ~pend_is_write & ~inflight.
  - write-eligible = pend_vld & pend_is_write & wr_data_full & ~inflight.
- Each channel has its own 2-state FSM (IDLE, OFFER).
- IDLE -> OFFER requires all of: cfg_enable=1, at least one eligible tag, and outst < MAX.
  - The chosen tag is the first eligible index at or above the pointer, wrapping modulo TAG_NUM.
  - The tag is registered; vld rises the next cycle, so offer latency is 1 cycle.
- In OFFER, vld and tag are held stable until rdy=1. There is no retraction, even if cfg_enable drops or pend_vld deasserts.
- Handshake is vld & rdy, and returns the channel to IDLE. On handshake:
  - the inflight[tag] bit is set;
  - issued_pulse[tag]=1 for exactly one cycle;
  - outst increments;
  - the pointer becomes (tag+1) mod TAG_NUM.
- A new offer may start the cycle after the handshake, giving at most one offer per 2 cycles per channel.
- Read and write channels run concurrently. issued_pulse may have 2 bits set in the same cycle (distinct tags, since direction partitions the tag set).
- done_vld with inflight[tag]=1 of the matching direction clears inflight[tag] and decrements outst.
- Handshake and done in the same cycle on the same channel: outst is unchanged and both bitmap updates apply.
  - A done may retire the very tag being accepted in that cycle only if that tag was already in flight, which is an error; see the next rule.
- done for a tag not in flight, or of the wrong direction, is ignored for the counter and bitmap and sets sched_err. sched_err clears only on reset.
- Handshake while outst == MAX is impossible by construction. Done while outst == 0 follows the sched_err rule; the counter never underflows.
- A tag whose pend_vld stays high after issue is masked by inflight until its done, so it is never re-issued.
- Asserting presetn mid-offer drops vld immediately (async reset). Any in-flight state is discarded.

Test Plan:
- Reset, then set pend_vld=0x0006 with is_write=0 and rdy=1 -> rd_issue_tag 1 and then 2, each vld one cycle after IDLE; issued_pulse=0x0002 then 0x0004; rd_outst=2.
- Tags 3, 5, 9 pending read with pointer=6 -> order 9, 3, 5 (wrap-around); pointer ends at 6.
- Write tag 4 pending with wr_data_full[4]=0 for 10 cycles -> no wr_issue_vld; set it to 1 -> offer tag 4 within 2 cycles. Hold rdy=0 for 5 cycles and drop cfg_enable -> vld and tag stay stable until rdy.
- MAX_RD_OUTST=2 with 4 read tags pending -> only 2 issued; rd_done for the first -> third issued; rd_outst stays at 2.
- Read handshake on tag 7 and rd_done on tag 1 in the same cycle -> rd_outst unchanged; inflight bit 7 set and bit 1 clear. Concurrent write handshake on tag 8 -> issued_pulse=0x0180.
- wr_done_tag=2 while tag 2 is not in flight -> sched_err=1 and sticky; wr_outst unchanged, including when it is 0.

Source files
------------

// File: rtl/apb2axi_txn_sched_if.sv
// ---------------------------------------------------------------------------
// apb2axi_txn_sched_if
//
// Bundle of every non-clock signal of the transaction issue scheduler.
//
//   cfg_enable      : when low, no new issue offers are started
//   pend_vld        : per-tag "pending issue" flags from the tag directory
//   pend_is_write   : per-tag direction (1 = write)
//   wr_data_full    : per-tag "write data fully buffered"
//   rd_issue_*      : read issue offer (vld/tag out, rdy in)
//   wr_issue_*      : write issue offer (vld/tag out, rdy in)
//   issued_pulse    : one-cycle per-tag flag, tag has just been issued
//   rd_done_*       : read completion (last beat seen)
//   wr_done_*       : write completion (B response seen)
//   rd_outst        : read tags in flight
//   wr_outst        : write tags in flight
//   sched_err       : sticky protocol error flag
//
// Modports:
//   master : the scheduler side (drives offers, counters, pulses, error)
//   slave  : the environment (directory + AXI request builders)
// ---------------------------------------------------------------------------
interface apb2axi_txn_sched_if #(
  parameter int TAG_NUM = 16,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 5
);

  logic               cfg_enable;
  logic [TAG_NUM-1:0] pend_vld;
  logic [TAG_NUM-1:0] pend_is_write;
  logic [TAG_NUM-1:0] wr_data_full;

  logic               rd_issue_vld;
  logic [TAG_W-1:0]   rd_issue_tag;
  logic               rd_issue_rdy;

  logic               wr_issue_vld;
  logic [TAG_W-1:0]   wr_issue_tag;
  logic               wr_issue_rdy;

  logic [TAG_NUM-1:0] issued_pulse;

  logic               rd_done_vld;
  logic [TAG_W-1:0]   rd_done_tag;
  logic               wr_done_vld;
  logic [TAG_W-1:0]   wr_done_tag;

  logic [CNT_W-1:0]   rd_outst;
  logic [CNT_W-1:0]   wr_outst;
  logic               sched_err;

  modport master (
    input  cfg_enable, pend_vld, pend_is_write, wr_data_full,
    output rd_issue_vld, rd_issue_tag,
    input  rd_issue_rdy,
    output wr_issue_vld, wr_issue_tag,
    input  wr_issue_rdy,
    output issued_pulse,
    input  rd_done_vld, rd_done_tag, wr_done_vld, wr_done_tag,
    output rd_outst, wr_outst, sched_err
  );

  modport slave (
    output cfg_enable, pend_vld, pend_is_write, wr_data_full,
    input  rd_issue_vld, rd_issue_tag,
    output rd_issue_rdy,
    input  wr_issue_vld, wr_issue_tag,
    output wr_issue_rdy,
    input  issued_pulse,
    output rd_done_vld, rd_done_tag, wr_done_vld, wr_done_tag,
    input  rd_outst, wr_outst, sched_err
  );

endinterface

// File: rtl/apb2axi_txn_sched.sv
// ---------------------------------------------------------------------------
// apb2axi_txn_sched
//
// Issue scheduler between the tag directory and the AXI read/write request
// builders. Each direction has its own channel: a round-robin pick over the
// eligible tags, a two-state offer FSM, an in-flight bitmap and an
// outstanding counter. Completions retire tags; a completion for a tag that
// is not in flight in that direction is ignored and raises a sticky error.
//
// Ports:
//   pclk     : clock
//   presetn  : asynchronous, active-low reset
//   bus      : apb2axi_txn_sched_if.master (see the interface for signals)
//
// Parameters:
//   TAG_NUM, TAG_W        : number of tags and tag index width
//   MAX_RD_OUTST/WR_OUTST : per-direction in-flight limits (1..TAG_NUM)
//   CNT_W                 : outstanding counter width, must hold TAG_NUM
// ---------------------------------------------------------------------------
module apb2axi_txn_sched #(
  parameter int TAG_NUM      = 16,
  parameter int TAG_W        = 4,
  parameter int MAX_RD_OUTST = 8,
  parameter int MAX_WR_OUTST = 8,
  parameter int CNT_W        = 5
) (
  input logic                  pclk,
  input logic                  presetn,
  apb2axi_txn_sched_if.master  bus
);

  localparam int CH_RD = 0;
  localparam int CH_WR = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } ch_state_e;

  // Per-channel views, index CH_RD / CH_WR.
  logic [1:0][TAG_NUM-1:0] elig;
  logic [1:0][TAG_NUM-1:0] dir_inflight;
  logic [1:0][TAG_NUM-1:0] set_mask;
  logic [1:0][TAG_W-1:0]   offer_tag;
  logic [1:0][TAG_W-1:0]   done_tag;
  logic [1:0][CNT_W-1:0]   outst;
  logic [1:0]              offer_vld;
  logic [1:0]              req_rdy;
  logic [1:0]              done_vld;
  logic [1:0]              err_bit;

  logic [TAG_NUM-1:0]      inflight;
  logic [TAG_NUM-1:0]      issued_pulse_reg;
  logic                    sched_err_reg;

  // A tag in flight in either direction is never offered again until its
  // completion retires it, even if the directory keeps pend_vld high.
  assign inflight     = dir_inflight[CH_RD] | dir_inflight[CH_WR];
  assign elig[CH_RD]  = bus.pend_vld & ~bus.pend_is_write & ~inflight;
  assign elig[CH_WR]  = bus.pend_vld & bus.pend_is_write & bus.wr_data_full
                        & ~inflight;

  assign req_rdy      = {bus.wr_issue_rdy, bus.rd_issue_rdy};
  assign done_vld     = {bus.wr_done_vld, bus.rd_done_vld};
  assign done_tag[CH_RD] = bus.rd_done_tag;
  assign done_tag[CH_WR] = bus.wr_done_tag;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic [CNT_W-1:0] MAX_OUTST =
        (gi == CH_RD) ? CNT_W'(MAX_RD_OUTST) : CNT_W'(MAX_WR_OUTST);

      ch_state_e          state_reg, state_next;
      logic [TAG_W-1:0]   tag_reg, tag_next;
      logic [TAG_W-1:0]   ptr_reg, ptr_next;
      logic [CNT_W-1:0]   outst_reg, outst_next;
      logic [TAG_NUM-1:0] inflight_reg, inflight_next;
      logic [TAG_NUM-1:0] clr_mask;
      logic [TAG_W-1:0]   pick_tag;
      logic [TAG_W:0]     pick_idx;
      logic               pick_found;
      logic               hs;
      logic               done_in_range;
      logic               done_ok;

      // Round-robin pick: first eligible index at or above the pointer,
      // wrapping. Scanning offsets from high to low lets the smallest
      // offset win. The sum is one bit wider so the wrap also works when
      // TAG_NUM is not a power of two.
      always_comb begin
        pick_found = 1'b0;
        pick_tag   = '0;
        pick_idx   = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
          pick_idx = {1'b0, ptr_reg} + (TAG_W+1)'(i);
          if (pick_idx >= (TAG_W+1)'(TAG_NUM)) begin
            pick_idx = pick_idx - (TAG_W+1)'(TAG_NUM);
          end
          if (elig[gi][pick_idx[TAG_W-1:0]]) begin
            pick_found = 1'b1;
            pick_tag   = pick_idx[TAG_W-1:0];
          end
        end
      end

      assign hs            = (state_reg == ST_OFFER) && req_rdy[gi];
      assign done_in_range = ({1'b0, done_tag[gi]} < (TAG_W+1)'(TAG_NUM));
      // A completion only counts if this direction has the tag in flight;
      // a tag being accepted this very cycle is not yet in flight.
      assign done_ok       = done_vld[gi] && done_in_range
                             && inflight_reg[done_tag[gi]];

      assign set_mask[gi]  = {{(TAG_NUM-1){1'b0}}, hs} << tag_reg;
      assign clr_mask      = {{(TAG_NUM-1){1'b0}}, done_ok} << done_tag[gi];

      // Offer FSM: the registered tag makes the offer appear one cycle after
      // the pick, and an offer is never withdrawn once made.
      always_comb begin
        state_next = state_reg;
        tag_next   = tag_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
          ST_IDLE: begin
            if (bus.cfg_enable && pick_found && (outst_reg < MAX_OUTST)) begin
              state_next = ST_OFFER;
              tag_next   = pick_tag;
            end
          end
          ST_OFFER: begin
            if (req_rdy[gi]) begin
              state_next = ST_IDLE;
              ptr_next   = (tag_reg == TAG_W'(TAG_NUM - 1)) ? '0
                                                           : tag_reg + TAG_W'(1);
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end

      // Bitmap and counter: accept and retire may coincide, in which case
      // both bitmap edits apply and the counter holds.
      always_comb begin
        inflight_next = (inflight_reg | set_mask[gi]) & ~clr_mask;
        outst_next    = outst_reg;
        if (hs && !done_ok) begin
          outst_next = outst_reg + CNT_W'(1);
        end else if (!hs && done_ok) begin
          outst_next = outst_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          state_reg    <= ST_IDLE;
          tag_reg      <= '0;
          ptr_reg      <= '0;
          outst_reg    <= '0;
          inflight_reg <= '0;
        end else begin
          state_reg    <= state_next;
          tag_reg      <= tag_next;
          ptr_reg      <= ptr_next;
          outst_reg    <= outst_next;
          inflight_reg <= inflight_next;
        end
      end

      assign offer_vld[gi]    = (state_reg == ST_OFFER);
      assign offer_tag[gi]    = tag_reg;
      assign outst[gi]        = outst_reg;
      assign dir_inflight[gi] = inflight_reg;
      assign err_bit[gi]      = done_vld[gi] && !done_ok;
    end
  endgenerate

  // The issued pulse is registered so it lands in the same cycle the
  // in-flight bit and the counter reflect the accepted tag. Directions
  // partition the tag set, so the two masks never overlap.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      issued_pulse_reg <= '0;
      sched_err_reg    <= 1'b0;
    end else begin
      issued_pulse_reg <= set_mask[CH_RD] | set_mask[CH_WR];
      sched_err_reg    <= sched_err_reg | (|err_bit);
    end
  end

  assign bus.rd_issue_vld = offer_vld[CH_RD];
  assign bus.rd_issue_tag = offer_tag[CH_RD];
  assign bus.wr_issue_vld = offer_vld[CH_WR];
  assign bus.wr_issue_tag = offer_tag[CH_WR];
  assign bus.issued_pulse = issued_pulse_reg;
  assign bus.rd_outst     = outst[CH_RD];
  assign bus.wr_outst     = outst[CH_WR];
  assign bus.sched_err    = sched_err_reg;

endmodule

// File: tb/tb_apb2axi_txn_sched.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_txn_sched
//
// Directed bench for apb2axi_txn_sched with MAX_RD_OUTST=2 so the read
// limit is reachable. Expected issue order is queued when pending tags are
// presented and popped when the scheduler makes an offer. Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_apb2axi_txn_sched;

  localparam int TAG_NUM = 16;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 5;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  always #5 pclk = ~pclk;

  apb2axi_txn_sched_if #(.TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .CNT_W(CNT_W)) sif ();

  apb2axi_txn_sched #(
    .TAG_NUM     (TAG_NUM),
    .TAG_W       (TAG_W),
    .MAX_RD_OUTST(2),
    .MAX_WR_OUTST(8),
    .CNT_W       (CNT_W)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (sif.master)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int rd_q[$];
  int wr_q[$];

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic rd_done(input int t);
    sif.rd_done_vld = 1'b1;
    sif.rd_done_tag = TAG_W'(t);
    $display("rd done tag=%0d", t);
    step();
    sif.rd_done_vld = 1'b0;
  endtask

  task automatic wr_done(input int t);
    sif.wr_done_vld = 1'b1;
    sif.wr_done_tag = TAG_W'(t);
    $display("wr done tag=%0d", t);
    step();
    sif.wr_done_vld = 1'b0;
  endtask

  // Wait for the next read offer (rdy held high), check it against the
  // scoreboard, drop the tag's pending flag, check the issued pulse and
  // optionally retire the tag right away.
  task automatic take_rd(input bit retire);
    int  exp_tag;
    int  t;
    bit  seen;
    exp_tag = (rd_q.size() > 0) ? rd_q.pop_front() : -1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sif.rd_issue_vld) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("rd_offer_seen", 32'(seen), 32'd1);
    if (seen) begin
      t = int'(sif.rd_issue_tag);
      $display("rd issue tag=%0d", t);
      chk("rd_issue_tag", 32'(t), 32'(exp_tag));
      sif.pend_vld[t] = 1'b0;
      step();
      chk("rd_issued_pulse", 32'(sif.issued_pulse[t]), 32'd1);
      if (retire) rd_done(t);
    end
  endtask

  initial begin
    bit any_vld;
    bit stable;
    bit seen;
    logic [CNT_W-1:0] outst_before;

    sif.cfg_enable    = 1'b0;
    sif.pend_vld      = '0;
    sif.pend_is_write = '0;
    sif.wr_data_full  = '0;
    sif.rd_issue_rdy  = 1'b0;
    sif.wr_issue_rdy  = 1'b0;
    sif.rd_done_vld   = 1'b0;
    sif.rd_done_tag   = '0;
    sif.wr_done_vld   = 1'b0;
    sif.wr_done_tag   = '0;

    // Reset state.
    step();
    step();
    chk("rst_rd_vld", 32'(sif.rd_issue_vld), 32'd0);
    chk("rst_wr_vld", 32'(sif.wr_issue_vld), 32'd0);
    chk("rst_pulse", 32'(sif.issued_pulse), 32'd0);
    chk("rst_rd_outst", 32'(sif.rd_outst), 32'd0);
    chk("rst_wr_outst", 32'(sif.wr_outst), 32'd0);
    chk("rst_err", 32'(sif.sched_err), 32'd0);
    presetn = 1'b1;
    step();

    // Basic read issue: tags 1 then 2, one-cycle latency from IDLE.
    sif.cfg_enable   = 1'b1;
    sif.rd_issue_rdy = 1'b1;
    sif.pend_vld     = 16'h0006;
    rd_q.push_back(1);
    rd_q.push_back(2);
    step();
    chk("t1_vld_a", 32'(sif.rd_issue_vld), 32'd1);
    chk("t1_tag_a", 32'(sif.rd_issue_tag), 32'(rd_q.pop_front()));
    step();
    chk("t1_pulse_a", 32'(sif.issued_pulse), 32'h0002);
    chk("t1_vld_gap", 32'(sif.rd_issue_vld), 32'd0);
    chk("t1_outst_a", 32'(sif.rd_outst), 32'd1);
    step();
    chk("t1_vld_b", 32'(sif.rd_issue_vld), 32'd1);
    chk("t1_tag_b", 32'(sif.rd_issue_tag), 32'(rd_q.pop_front()));
    step();
    chk("t1_pulse_b", 32'(sif.issued_pulse), 32'h0004);
    chk("t1_outst_b", 32'(sif.rd_outst), 32'd2);

    // Read limit of 2: tags 10/11 wait while 1/2 (still pending) are masked.
    sif.pend_vld = sif.pend_vld | 16'h0C00;
    any_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      any_vld |= sif.rd_issue_vld;
    end
    chk("max_no_offer", 32'(any_vld), 32'd0);
    chk("max_outst", 32'(sif.rd_outst), 32'd2);
    sif.pend_vld[1] = 1'b0;
    sif.pend_vld[2] = 1'b0;
    rd_done(1);
    chk("max_outst_after_done", 32'(sif.rd_outst), 32'd1);
    rd_q.push_back(10);
    take_rd(1'b0);
    chk("max_outst_refill", 32'(sif.rd_outst), 32'd2);
    any_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_vld |= sif.rd_issue_vld;
    end
    chk("max_still_blocked", 32'(any_vld), 32'd0);

    // Drain, then issue tag 5 so the read pointer sits at 6.
    rd_done(2);
    rd_q.push_back(11);
    take_rd(1'b1);
    rd_done(10);
    chk("drain_outst", 32'(sif.rd_outst), 32'd0);
    sif.pend_vld = 16'h0020;
    rd_q.push_back(5);
    take_rd(1'b1);

    // Wrap-around order from pointer 6: 9, 3, 5.
    sif.pend_vld = 16'h0228;
    rd_q.push_back(9);
    rd_q.push_back(3);
    rd_q.push_back(5);
    take_rd(1'b1);
    take_rd(1'b1);
    take_rd(1'b1);
    chk("rr_outst", 32'(sif.rd_outst), 32'd0);
    // Pointer ended at 6: tag 7 must win over tag 4.
    sif.pend_vld = 16'h0090;
    rd_q.push_back(7);
    rd_q.push_back(4);
    take_rd(1'b1);
    take_rd(1'b1);

    // Write gated by wr_data_full, then a stalled offer holds stable.
    sif.pend_vld[4]      = 1'b1;
    sif.pend_is_write[4] = 1'b1;
    any_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_vld |= sif.wr_issue_vld;
    end
    chk("wr_not_full_no_offer", 32'(any_vld), 32'd0);
    sif.wr_data_full[4] = 1'b1;
    wr_q.push_back(4);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (sif.wr_issue_vld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wr_offer_seen", 32'(seen), 32'd1);
    chk("wr_issue_tag", 32'(sif.wr_issue_tag), 32'(wr_q.pop_front()));
    $display("wr offer tag=%0d (stalled)", sif.wr_issue_tag);
    sif.cfg_enable  = 1'b0;
    sif.pend_vld[4] = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!sif.wr_issue_vld || sif.wr_issue_tag != TAG_W'(4)) stable = 1'b0;
    end
    chk("wr_offer_stable", 32'(stable), 32'd1);
    sif.wr_issue_rdy = 1'b1;
    step();
    sif.wr_issue_rdy = 1'b0;
    sif.cfg_enable   = 1'b1;
    chk("wr_pulse", 32'(sif.issued_pulse), 32'h0010);
    chk("wr_outst_a", 32'(sif.wr_outst), 32'd1);

    // Concurrent: read tag 7 and write tag 8 accepted while tag 1 retires.
    sif.pend_vld = 16'h0002;
    rd_q.push_back(1);
    take_rd(1'b0);
    sif.rd_issue_rdy     = 1'b0;
    sif.pend_vld         = 16'h0182;
    sif.pend_is_write[8] = 1'b1;
    sif.wr_data_full[8]  = 1'b1;
    step();
    step();
    chk("cc_rd_vld", 32'(sif.rd_issue_vld), 32'd1);
    chk("cc_rd_tag", 32'(sif.rd_issue_tag), 32'd7);
    chk("cc_wr_vld", 32'(sif.wr_issue_vld), 32'd1);
    chk("cc_wr_tag", 32'(sif.wr_issue_tag), 32'd8);
    outst_before = sif.rd_outst;
    sif.rd_issue_rdy = 1'b1;
    sif.wr_issue_rdy = 1'b1;
    sif.pend_vld[8]  = 1'b0;
    $display("rd issue tag=7, wr issue tag=8, rd done tag=1");
    sif.rd_done_vld = 1'b1;
    sif.rd_done_tag = TAG_W'(1);
    step();
    sif.rd_done_vld  = 1'b0;
    sif.rd_issue_rdy = 1'b0;
    sif.wr_issue_rdy = 1'b0;
    chk("cc_pulse", 32'(sif.issued_pulse), 32'h0180);
    chk("cc_rd_outst", 32'(sif.rd_outst), 32'(outst_before));
    chk("cc_wr_outst", 32'(sif.wr_outst), 32'd2);
    // Tag 1 was freed (re-offered); tag 7 stays masked.
    step();
    chk("cc_reoffer_vld", 32'(sif.rd_issue_vld), 32'd1);
    chk("cc_reoffer_tag", 32'(sif.rd_issue_tag), 32'd1);
    sif.rd_issue_rdy = 1'b1;
    sif.pend_vld[1]  = 1'b0;
    step();
    chk("cc_reoffer_pulse", 32'(sif.issued_pulse), 32'h0002);
    rd_done(1);
    any_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      any_vld |= sif.rd_issue_vld;
    end
    chk("cc_tag7_masked", 32'(any_vld), 32'd0);
    chk("cc_rd_outst_b", 32'(sif.rd_outst), 32'd1);

    // Protocol errors: unknown tag, wrong direction, and done at zero.
    chk("err_clear_before", 32'(sif.sched_err), 32'd0);
    wr_done(2);
    chk("err_set", 32'(sif.sched_err), 32'd1);
    chk("err_wr_outst", 32'(sif.wr_outst), 32'd2);
    wr_done(7);
    chk("err_wrongdir_rd_outst", 32'(sif.rd_outst), 32'd1);
    chk("err_wrongdir_wr_outst", 32'(sif.wr_outst), 32'd2);
    rd_done(8);
    chk("err_wrongdir2_rd_outst", 32'(sif.rd_outst), 32'd1);
    chk("err_wrongdir2_wr_outst", 32'(sif.wr_outst), 32'd2);
    wr_done(4);
    wr_done(8);
    chk("err_wr_outst_zero", 32'(sif.wr_outst), 32'd0);
    wr_done(2);
    chk("err_no_underflow", 32'(sif.wr_outst), 32'd0);
    chk("err_sticky", 32'(sif.sched_err), 32'd1);
    sif.pend_vld[7] = 1'b0;
    rd_done(7);
    chk("err_rd_outst_zero", 32'(sif.rd_outst), 32'd0);

    // Asynchronous reset in the middle of an offer.
    sif.rd_issue_rdy = 1'b0;
    sif.pend_vld     = 16'h0008;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (sif.rd_issue_vld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_offer_seen", 32'(seen), 32'd1);
    #2;
    presetn = 1'b0;
    #1;
    chk("rst_async_vld", 32'(sif.rd_issue_vld), 32'd0);
    chk("rst_async_err", 32'(sif.sched_err), 32'd0);
    sif.pend_vld = '0;
    step();
    presetn = 1'b1;
    step();
    chk("rst_after_outst", 32'(sif.rd_outst), 32'd0);
    chk("rst_after_pulse", 32'(sif.issued_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
